hazard_ctrl: RTL and testbench

- Issue/stall controller for the in-order ALU pipeline; sits between instruction fetch and the S1 decode register.
- Tracks in-flight register writes in a shift scoreboard and detects RAW hazards between the incoming instruction and those writes.
- Stalls fetch and injects bubbles into S1 until each hazard clears.
- Sequences pipeline drain on flush requests.

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_sb.sv | 57 +++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ALU-pipeline issue/stall controller (package pipe_pkg):
// instruction field positions, FSM state encoding and the scoreboard entry layout.
package pipe_pkg;

  localparam int WE_BIT    = 30;
  localparam int DS_BIT    = 29;
  localparam int WSEL_HI   = 25;
  localparam int WSEL_LO   = 21;
  localparam int RS1_HI    = 20;
  localparam int RS1_LO    = 16;
  localparam int RS2_HI    = 15;
  localparam int RS2_LO    = 11;
  localparam int MAX_SEL_W = WSEL_HI - WSEL_LO + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [MAX_SEL_W-1:0] wsel;
  } sb_entry_t;

endpackage

// File: rtl/hazard_sb.sv
// Shift scoreboard of in-flight register writes plus RAW comparators against
// the incoming instruction's read selects. Entry 0 is the youngest.
module hazard_sb
  import pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             we_i,
  input  logic             ds_i,
  input  logic [SEL_W-1:0] wsel_i,
  input  logic [SEL_W-1:0] rs1_i,
  input  logic [SEL_W-1:0] rs2_i,
  output logic             hz1_o,
  output logic             hz2_o,
  output logic             empty_o,
  output logic [3:0]       count_o
);

  sb_entry_t [PIPE_DEPTH-1:0] sb_q;
  sb_entry_t [PIPE_DEPTH-1:0] sb_d;

  always_comb begin
    sb_d          = sb_q;
    sb_d[0].valid = push_i;
    sb_d[0].we    = push_i & we_i;
    sb_d[0].wsel  = push_i ? MAX_SEL_W'(wsel_i) : '0;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // The register file has no bypass, so the oldest entry still counts as a hazard.
  always_comb begin
    hz1_o   = 1'b0;
    hz2_o   = 1'b0;
    empty_o = 1'b1;
    count_o = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (sb_q[k].valid) empty_o = 1'b0;
      if (sb_q[k].valid && sb_q[k].we) begin
        count_o = count_o + 4'd1;
        if (sb_q[k].wsel == MAX_SEL_W'(rs1_i)) hz1_o = 1'b1;
        if (!ds_i && sb_q[k].wsel == MAX_SEL_W'(rs2_i)) hz2_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall controller between fetch and the S1 decode register.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [31:0] inst_in,
  input  logic        flush_req,
  output logic        issue,
  output logic        stall,
  output logic        bubble,
  output logic        flush_done,
  output logic        busy,
  output logic [3:0]  sb_count
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] issue_count
`endif
);

  state_e state_q, state_d;
  logic   hz1, hz2, sb_empty, hazard;
  logic   unused_inst_bits;

  assign unused_inst_bits = ^{inst_in[31], inst_in[28:26], inst_in[10:0]};

  hazard_sb #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .SEL_W      (SEL_W)
  ) u_sb (
    .clk     (clk),
    .rst     (reset),
    .push_i  (issue),
    .we_i    (inst_in[WE_BIT]),
    .ds_i    (inst_in[DS_BIT]),
    .wsel_i  (inst_in[WSEL_LO +: SEL_W]),
    .rs1_i   (inst_in[RS1_LO +: SEL_W]),
    .rs2_i   (inst_in[RS2_LO +: SEL_W]),
    .hz1_o   (hz1),
    .hz2_o   (hz2),
    .empty_o (sb_empty),
    .count_o (sb_count)
  );

  assign hazard = inst_valid & (hz1 | hz2);
  assign busy   = (state_q != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN, STALL: begin
        if (flush_req)   state_d = DRAIN;
        else if (hazard) state_d = STALL;
        else             state_d = RUN;
      end
      DRAIN:   if (sb_empty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs are held low for as long as reset is asserted, not just until the next edge.
  always_comb begin
    issue      = 1'b0;
    stall      = 1'b0;
    bubble     = 1'b0;
    flush_done = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN, STALL: begin
          if (flush_req) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end else begin
            issue  = inst_valid & ~hazard;
            stall  = hazard;
            bubble = hazard;
          end
        end
        DRAIN: begin
          bubble = 1'b1;
          if (sb_empty) flush_done = 1'b1;
          else          stall      = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, issue_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      issue_count_q  <= '0;
    end else begin
      if (stall && state_q != DRAIN && stall_cycles_q != 32'hFFFF_FFFF)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (issue && issue_count_q != 32'hFFFF_FFFF)
        issue_count_q <= issue_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign issue_count  = issue_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (PIPE_DEPTH=3): directed hazard/flush/reset
// sequences followed by a random issue stream checked against a reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst_in;
  logic        flush_req;
  logic        issue, stall, bubble, flush_done, busy;
  logic [3:0]  sb_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  hazard_ctrl #(
    .PIPE_DEPTH (3),
    .SEL_W      (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_in    (inst_in),
    .flush_req  (flush_req),
    .issue      (issue),
    .stall      (stall),
    .bubble     (bubble),
    .flush_done (flush_done),
    .busy       (busy),
    .sb_count   (sb_count)
  );

  always #5 clk = ~clk;

  // observed vector layout: {issue, stall, bubble, flush_done, busy, sb_count}
  wire [8:0] obs = {issue, stall, bubble, flush_done, busy, sb_count};

  function automatic logic [8:0] ev(bit i, bit s, bit b, bit d, bit bz, logic [3:0] c);
    return {i, s, b, d, bz, c};
  endfunction

  task automatic check_vec(string tag, logic [8:0] act, logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (issue,stall,bubble,flush_done,busy,sb_count[3:0]) at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic compare_out(string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected queue empty at %0t", tag, $time);
    end else begin
      e = exp_q.pop_front();
      check_vec(tag, obs, e);
    end
  endtask

  // Drive one cycle's inputs (called at posedge+1), check at the following negedge.
  task automatic step(string tag, bit v, logic [31:0] inst, bit fl, logic [8:0] e);
    inst_valid = v;
    inst_in    = inst;
    flush_req  = fl;
    exp_q.push_back(e);
    @(negedge clk);
    compare_out(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(string tag, int n, logic [3:0] c0, logic [3:0] c1, logic [3:0] c2);
    logic [3:0] cs [3];
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, 1'b0, ev(0, 0, 0, 0, 0, cs[i % 3]));
  endtask

  bit         hv [3];
  logic [4:0] hs [3];
  bit         prev_hz;

  initial begin
    reset      = 1'b1;
    inst_valid = 1'b1;
    inst_in    = 32'h0003_0000;
    flush_req  = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    compare_out("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // back-to-back RAW on rs1
    step("raw_rs1_w",  1, 32'h4060_0000, 0, ev(1, 0, 0, 0, 0, 1'b0));
    step("raw_rs1_s1", 1, 32'h0003_0000, 0, ev(0, 1, 1, 0, 0, 1));
    step("raw_rs1_s2", 1, 32'h0003_0000, 0, ev(0, 1, 1, 0, 1, 1));
    step("raw_rs1_s3", 1, 32'h0003_0000, 0, ev(0, 1, 1, 0, 1, 1));
    step("raw_rs1_go", 1, 32'h0003_0000, 0, ev(1, 0, 0, 0, 1, 0));
    idle("raw_rs1_idle", 3, 0, 0, 0);

    // rs2 unused with immediate source
    step("imm_w",  1, 32'h4060_0000, 0, ev(1, 0, 0, 0, 0, 0));
    step("imm_rd", 1, 32'h2000_1800, 0, ev(1, 0, 0, 0, 0, 1));
    idle("imm_idle", 3, 1, 1, 0);

    // rs2 register RAW
    step("raw_rs2_w",  1, 32'h4060_0000, 0, ev(1, 0, 0, 0, 0, 0));
    step("raw_rs2_s1", 1, 32'h0000_1800, 0, ev(0, 1, 1, 0, 0, 1));
    step("raw_rs2_s2", 1, 32'h0000_1800, 0, ev(0, 1, 1, 0, 1, 1));
    step("raw_rs2_s3", 1, 32'h0000_1800, 0, ev(0, 1, 1, 0, 1, 1));
    step("raw_rs2_go", 1, 32'h0000_1800, 0, ev(1, 0, 0, 0, 1, 0));
    idle("raw_rs2_idle", 3, 0, 0, 0);

    // non-writer creates no hazard
    step("nowr_w",  1, 32'h0060_0000, 0, ev(1, 0, 0, 0, 0, 0));
    step("nowr_rd", 1, 32'h0003_0000, 0, ev(1, 0, 0, 0, 0, 0));
    idle("nowr_idle", 3, 0, 0, 0);

    // flush and drain; flush_req held during DRAIN must be ignored
    step("flush_w",    1, 32'h4060_0000, 0, ev(1, 0, 0, 0, 0, 0));
    step("flush_req",  0, 32'h0,         1, ev(0, 1, 1, 0, 0, 1));
    step("flush_dr1",  1, 32'h0003_0000, 1, ev(0, 1, 1, 0, 1, 1));
    step("flush_dr2",  1, 32'h0003_0000, 0, ev(0, 1, 1, 0, 1, 1));
    step("flush_done", 1, 32'h0003_0000, 0, ev(0, 0, 1, 1, 1, 0));
    step("flush_run",  1, 32'h0003_0000, 0, ev(1, 0, 0, 0, 0, 0));
    idle("flush_idle", 3, 0, 0, 0);

    // flush coinciding with a hazard: flush wins, so DRAIN follows even with no instruction
    step("fhz_w",    1, 32'h4060_0000, 0, ev(1, 0, 0, 0, 0, 0));
    step("fhz_req",  1, 32'h0003_0000, 1, ev(0, 1, 1, 0, 0, 1));
    step("fhz_dr1",  0, 32'h0,         0, ev(0, 1, 1, 0, 1, 1));
    step("fhz_dr2",  0, 32'h0,         0, ev(0, 1, 1, 0, 1, 1));
    step("fhz_done", 0, 32'h0,         0, ev(0, 0, 1, 1, 1, 0));
    idle("fhz_idle", 2, 0, 0, 0);

    // asynchronous reset in the middle of a stall
    step("arst_w",  1, 32'h4060_0000, 0, ev(1, 0, 0, 0, 0, 0));
    step("arst_s1", 1, 32'h0003_0000, 0, ev(0, 1, 1, 0, 0, 1));
    inst_valid = 1'b1;
    inst_in    = 32'h0003_0000;
    flush_req  = 1'b0;
    exp_q.push_back(ev(0, 1, 1, 0, 1, 1));
    @(negedge clk);
    compare_out("arst_s2");
    #1;
    reset = 1'b1;
    #1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    compare_out("arst_held");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("arst_go", 1, 32'h0003_0000, 0, ev(1, 0, 0, 0, 0, 0));
    idle("arst_idle", 3, 0, 0, 0);

    // random stream without flushes, checked against a write-history model
    for (int k = 0; k < 3; k++) begin
      hv[k] = 1'b0;
      hs[k] = '0;
    end
    prev_hz = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bit         v, we, ds, hz, iss;
      logic [4:0] ws, r1, r2;
      logic [3:0] cnt;
      logic [31:0] inst;
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      ds = $urandom_range(0, 1);
      ws = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      inst = {1'b0, we, ds, 3'($urandom_range(0, 7)), ws, r1, r2, 11'($urandom_range(0, 2047))};
      hz  = 1'b0;
      cnt = '0;
      for (int k = 0; k < 3; k++) begin
        if (hv[k]) begin
          cnt = cnt + 4'd1;
          if (v && (hs[k] == r1 || (!ds && hs[k] == r2))) hz = 1'b1;
        end
      end
      iss = v && !hz;
      step("rand", v, inst, 0, ev(iss, hz, hz, 0, prev_hz, cnt));
      hv[2] = hv[1]; hs[2] = hs[1];
      hv[1] = hv[0]; hs[1] = hs[0];
      hv[0] = iss && we;
      hs[0] = ws;
      prev_hz = hz;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
